// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encodings, oversample ratio and
// default frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// (last_grant+1) mod NREQ and reports it one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_req_o
);

  logic [IDW-1:0] idx;
  logic           found;

  // Walk the ring starting just past the last winner; the first hit wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    idx         = '0;
    found       = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IDW'((int'(last_grant_i) + off) % NREQ);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
    any_req_o = found;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART transmit line between NREQ byte producers, granting
// them in round-robin order and timing each bit from the 16x s_tick.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);

  localparam int TW = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_END = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] ready_q, ready_d;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic [DBIT-1:0] sel_data;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (ptr_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx),
    .any_req_o    (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) sel_data = req_data[i*DBIT +: DBIT];
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    ready_d = '0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          ready_d = arb_grant;
          shreg_d = sel_data;
          gid_d   = arb_idx;
          busy_d  = 1'b1;
          tick_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == BIT_END) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == BIT_END) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == LAST_BIT) state_d = STOP;
            else                   bit_d   = bit_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        // The pointer only moves once a frame completes, so an aborted frame
        // never shifts the rotation.
        if (s_tick) begin
          if (tick_q == STOP_END) begin
            tick_d  = '0;
            busy_d  = 1'b0;
            ptr_d   = gid_q;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The line level is registered from the next state so tx lines up with it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      gid_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requesters are fed from per-port
// byte lists, expected grants are queued, and a monitor decodes every frame.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DBIT = 8;
  localparam int FRAME_TICKS = 160;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             s_tick = 1'b0;
  logic [NREQ-1:0]  vld = '0;
  logic [NREQ-1:0]  pulseMask = '0;
  logic [DBIT-1:0]  dat [NREQ];
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             tx;
  logic             busy;
  logic [IDW-1:0]   grant_id;

  int checks = 0;
  int failures = 0;
  bit tickEn = 1'b1;
  bit monBusy = 1'b0;

  typedef struct { int id; logic [7:0] data; } exp_t;
  exp_t expQ[$];

  logic [7:0] srcBuf [NREQ][16];
  int         srcHead [NREQ];
  int         srcTail [NREQ];

  assign req_valid = vld | pulseMask;
  assign req_data  = {dat[3], dat[2], dat[1], dat[0]};

  uart_tx_scheduler #(.NREQ(NREQ), .IDW(IDW), .DBIT(DBIT), .SB_TICK(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial forever #5 clk = ~clk;

  // A 16x tick every 4 clocks keeps each frame at 640 clocks.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      ph = (ph + 1) % 4;
      s_tick = tickEn && (ph == 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] d);
    srcBuf[id][srcTail[id]] = d;
    srcTail[id]++;
  endtask

  task automatic expectFrame(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    expQ.push_back(e);
  endtask

  // Requester model: hold valid/data until the ready pulse, then move on.
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      dat[i] = '0;
      srcHead[i] = 0;
      srcTail[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (vld[i] && req_ready[i]) srcHead[i]++;
        if (srcHead[i] < srcTail[i]) begin
          vld[i] = 1'b1;
          dat[i] = srcBuf[i][srcHead[i]];
        end else begin
          vld[i] = 1'b0;
        end
      end
    end
  end

  task automatic decodeFrame(input logic [7:0] d);
    int k = 0;
    int lastK = -1;
    int waited = 0;
    logic [7:0] rx = '0;
    bit aborted = 1'b0;
    while (k < FRAME_TICKS && !aborted) begin
      if (reset) begin
        aborted = 1'b1;
      end else begin
        if (k != lastK) begin
          lastK = k;
          if (k == 8) begin
            checkOutput("start_bit", {31'b0, tx}, 32'd0);
            checkOutput("busy_in_frame", {31'b0, busy}, 32'd1);
          end else if (k % 16 == 8 && k < 144) begin
            rx = {tx, rx[7:1]};
          end else if (k == 152) begin
            checkOutput("stop_bit", {31'b0, tx}, 32'd1);
          end else if (k == FRAME_TICKS - 1) begin
            checkOutput("busy_last_tick", {31'b0, busy}, 32'd1);
          end
        end
        if (s_tick) k++;
        waited++;
        if (waited > 30000) begin
          checkOutput("frame_timeout", k, FRAME_TICKS);
          aborted = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (!aborted) begin
      checkOutput("rx_byte", {24'b0, rx}, {24'b0, d});
      checkOutput("busy_after_frame", {31'b0, busy}, 32'd0);
      checkOutput("tx_idle_after_frame", {31'b0, tx}, 32'd1);
    end
  endtask

  // Monitor: every ready pulse pops the next expected grant and decodes its frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && req_ready != '0) begin
        monBusy = 1'b1;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_grant", {28'b0, req_ready}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("ready_onehot", {28'b0, req_ready}, 32'd1 << e.id);
          checkOutput("grant_id", {30'b0, grant_id}, e.id);
          decodeFrame(e.data);
        end
        monBusy = 1'b0;
      end
    end
  end

  function automatic bit srcPending();
    for (int i = 0; i < NREQ; i++) if (srcHead[i] < srcTail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic waitIdle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((expQ.size() != 0 || monBusy || busy || srcPending() || vld != '0) && n < 40000);
    checks++;
    if (n >= 40000) begin
      failures++;
      $display("[TB] FAIL %s_idle_timeout actual=%0d expected_left=0", tag, expQ.size());
    end
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (req_ready == '0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      failures++;
      $display("[TB] FAIL %s_ready_timeout actual=0 expected=pulse", tag);
    end
  endtask

  task automatic stimSlot();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", {31'b0, tx}, 32'd1);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_ready", {28'b0, req_ready}, 32'd0);
    checkOutput("reset_grant_id", {30'b0, grant_id}, 32'd0);
    reset = 1'b0;

    // Single byte 0xA5 from requester 0: line reads 0,1,0,1,0,0,1,0,1,1.
    stimSlot();
    applyStimulus(0, 8'hA5);
    expectFrame(0, 8'hA5);
    waitIdle("t1");

    // All four at once straight after reset go out 0,1,2,3.
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    stimSlot();
    applyStimulus(0, 8'h11); applyStimulus(1, 8'h22);
    applyStimulus(2, 8'h33); applyStimulus(3, 8'h44);
    expectFrame(0, 8'h11); expectFrame(1, 8'h22);
    expectFrame(2, 8'h33); expectFrame(3, 8'h44);
    waitIdle("t2");

    // Requesters 0 and 2 stay busy: grants must alternate.
    stimSlot();
    applyStimulus(0, 8'hA0); applyStimulus(0, 8'hA1); applyStimulus(0, 8'hA2);
    applyStimulus(2, 8'hB0); applyStimulus(2, 8'hB1); applyStimulus(2, 8'hB2);
    expectFrame(0, 8'hA0); expectFrame(2, 8'hB0);
    expectFrame(0, 8'hA1); expectFrame(2, 8'hB1);
    expectFrame(0, 8'hA2); expectFrame(2, 8'hB2);
    waitIdle("t3");

    // A 1-clk request from 1 during requester 3's frame must be ignored.
    stimSlot();
    applyStimulus(3, 8'hC3);
    expectFrame(3, 8'hC3);
    waitReady("t4");
    repeat (100) @(negedge clk);
    pulseMask = 4'b0010;
    @(negedge clk);
    pulseMask = 4'b0000;
    waitIdle("t4");
    for (int i = 0; i < 4; i++) begin
      repeat (50) @(negedge clk);
      checkOutput("t4_line_high", {31'b0, tx}, 32'd1);
      checkOutput("t4_not_busy", {31'b0, busy}, 32'd0);
    end

    // Move the pointer to 1, then abort requester 2's frame during data bit 3.
    stimSlot();
    applyStimulus(1, 8'hD1);
    expectFrame(1, 8'hD1);
    waitIdle("t5a");
    stimSlot();
    applyStimulus(2, 8'hD2);
    expectFrame(2, 8'hD2);
    waitReady("t5b");
    begin
      int t = 0;
      while (t < 72) begin
        @(negedge clk);
        if (s_tick) t++;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_tx_after_reset", {31'b0, tx}, 32'd1);
    checkOutput("t5_busy_after_reset", {31'b0, busy}, 32'd0);
    checkOutput("t5_ready_after_reset", {28'b0, req_ready}, 32'd0);
    reset = 1'b0;
    stimSlot();
    applyStimulus(3, 8'hE3); applyStimulus(0, 8'hE0);
    expectFrame(0, 8'hE0); expectFrame(3, 8'hE3);
    waitIdle("t5c");

    // Stall the tick during START: line held low, then the frame completes intact.
    stimSlot();
    applyStimulus(1, 8'h5C);
    expectFrame(1, 8'h5C);
    waitReady("t6");
    begin
      int t = 0;
      while (t < 5) begin
        @(negedge clk);
        if (s_tick) t++;
      end
    end
    tickEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (1000) @(negedge clk);
      checkOutput("t6_tx_held_low", {31'b0, tx}, 32'd0);
      checkOutput("t6_busy_held", {31'b0, busy}, 32'd1);
    end
    tickEn = 1'b1;
    waitIdle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
